// File: rtl/muldiv_hilo_if.sv
// Operand/control/result bundle between the EX stage and the HI/LO multiply-divide unit.
// The master drives the operands and start; the slave returns busy, done and HI/LO.
interface muldiv_hilo_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ctrl;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, ctrl, start, input busy, done, HI, LO);
  modport slave  (input A, B, ctrl, start, output busy, done, HI, LO);
endinterface

// File: rtl/muldiv_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// busy models the fixed latency; the result is formed from the latched operands at the commit edge.
module muldiv_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_hilo_if.slave  bus
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        r_state, w_next;
  op_e           r_op, w_op_in;
  logic [31:0]   r_a, r_b, r_hi, r_lo;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic          w_accept, w_commit, w_signed_div;
  logic [63:0]   w_prod_s, w_prod_u, w_result;
  logic [31:0]   w_div_n, w_div_d, w_q, w_r, w_quot, w_rem;

  assign w_op_in  = op_e'(bus.ctrl);
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.ctrl[2];
  assign w_commit = (r_state == S_RUN) && (r_cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_commit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One shared unsigned divider: signed DIV feeds it magnitudes and fixes signs afterwards.
  assign w_signed_div = (r_op == OP_DIV);
  assign w_div_n = (w_signed_div && r_a[31]) ? -r_a : r_a;
  assign w_div_d = (w_signed_div && r_b[31]) ? -r_b : r_b;

  always_comb begin
    w_q = '0;
    w_r = '0;
    if (r_b != '0) begin
      w_q = w_div_n / w_div_d;
      w_r = w_div_n % w_div_d;
    end
  end

  assign w_quot = (w_signed_div && (r_a[31] ^ r_b[31])) ? -w_q : w_q;
  assign w_rem  = (w_signed_div && r_a[31]) ? -w_r : w_r;

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV, OP_DIVU: begin
        if (r_b == '0) w_result = {r_a, 32'hFFFF_FFFF};
        else           w_result = {w_rem, w_quot};
      end
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op   <= OP_MULT;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_op  <= w_op_in;
        r_a   <= bus.A;
        r_b   <= bus.B;
        r_cnt <= bus.ctrl[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_commit) begin
          r_hi <= w_result[63:32];
          r_lo <= w_result[31:0];
        end
      end else if (bus.start && (w_op_in == OP_MTHI)) begin
        r_hi <= bus.A;
      end else if (bus.start && (w_op_in == OP_MTLO)) begin
        r_lo <= bus.A;
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule
